// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared direction codes, FSM state type and a popcount helper
//            for the button conditioning front end.
// Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // One-hot direction codes; bit order matches {U, D, R, L}
  localparam logic [3:0] BTN_U    = 4'd8;
  localparam logic [3:0] BTN_D    = 4'd4;
  localparam logic [3:0] BTN_R    = 4'd2;
  localparam logic [3:0] BTN_L    = 4'd1;
  localparam logic [3:0] BTN_NONE = 4'd0;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARM          = 3'd1,
    PULSE        = 3'd2,
    HOLD         = 3'd3,
    WAIT_RELEASE = 3'd4
  } btnState_t;

  // Number of buttons currently high
  function automatic logic [2:0] countHigh(input logic [3:0] levels);
    countHigh = {2'b00, levels[0]} + {2'b00, levels[1]}
              + {2'b00, levels[2]} + {2'b00, levels[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser followed by a debounce counter for one
//            raw button. The debounced level toggles only after the
//            synchronised sample has disagreed with it for DEBOUNCE_CYCLES
//            consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic btnLevel
);

  localparam int                c_cntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cntW-1:0] c_cntLast = c_cntW'(DEBOUNCE_CYCLES - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_level;
  logic [c_cntW-1:0] r_cnt;

  // Synchronise the raw input, then count consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btnRaw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= c_cntLast) begin
        // Last disagreeing sample of the window: accept the new level
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btnLevel = r_level;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Debounces the four board buttons and turns a single clean press
//            into a direction code (btns) plus a registered movement strobe
//            (btnClk). btns is stable whenever btnClk is high and on the
//            cycle before each rise.
// Options  : BTN_AUTOREPEAT_EN - compiles in the hold-to-repeat timer; when
//            undefined each accepted press yields exactly one strobe.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PULSE_CYCLES    = 4,
  parameter int REPEAT_DELAY    = 40_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnR,
  input  logic       btnL,
  output logic [3:0] btns,
  output logic       btnClk,
  output logic       btnHeld
);

  generate
    if (!(PULSE_CYCLES >= 1 && DEBOUNCE_CYCLES >= 1 &&
          PULSE_CYCLES < REPEAT_RATE && REPEAT_RATE <= REPEAT_DELAY)) begin : g_paramCheck
      $error("btn_conditioner: need PULSE_CYCLES < REPEAT_RATE <= REPEAT_DELAY");
    end
  endgenerate

  localparam int                 c_pulseW    = $clog2(PULSE_CYCLES + 1);
  localparam logic [c_pulseW-1:0] c_pulseLast = c_pulseW'(PULSE_CYCLES - 1);

  // Raw and debounced levels packed as {U, D, R, L} so a lone high bit
  // is directly the direction code.
  logic [3:0] w_raw;
  logic [3:0] w_level;

  assign w_raw = {btnU, btnD, btnR, btnL};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_debounce
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btnRaw  (w_raw[i]),
        .btnLevel(w_level[i])
      );
    end
  endgenerate

  btnState_t           r_state;
  btnState_t           w_stateNext;
  logic [3:0]          r_btns;
  logic [3:0]          w_btnsNext;
  logic                r_btnClk;
  logic                r_btnHeld;
  logic [c_pulseW-1:0] r_pulseCnt;
  logic [2:0]          w_numHigh;
  logic                w_repExpired;

  assign w_numHigh = countHigh(w_level);

`ifdef BTN_AUTOREPEAT_EN
  localparam int               c_repW     = $clog2(REPEAT_DELAY + 1);
  localparam logic [c_repW-1:0] c_repDelay = c_repW'(REPEAT_DELAY);
  localparam logic [c_repW-1:0] c_repRate  = c_repW'(REPEAT_RATE);

  // r_repCnt holds the number of edges since the last strobe rise, so the
  // comparison at edge rise+N sees exactly N.
  logic [c_repW-1:0] r_repCnt;
  logic              r_repFirst;

  assign w_repExpired = r_repFirst ? (r_repCnt >= c_repDelay)
                                   : (r_repCnt >= c_repRate);

  // Rise-to-rise repeat timer, restarted on every strobe rise
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_repCnt   <= '0;
      r_repFirst <= 1'b0;
    end else if (w_stateNext == PULSE && r_state != PULSE) begin
      r_repCnt   <= c_repW'(1);
      r_repFirst <= (r_state == ARM);
    end else if (w_stateNext == PULSE || w_stateNext == HOLD) begin
      if (r_repCnt < c_repDelay) begin
        r_repCnt <= r_repCnt + 1'b1;
      end
    end else begin
      r_repCnt   <= '0;
      r_repFirst <= 1'b0;
    end
  end
`else
  assign w_repExpired = 1'b0;
`endif

  // Next-state and next direction code
  always_comb begin
    w_stateNext = r_state;
    w_btnsNext  = r_btns;
    case (r_state)
      IDLE: begin
        w_btnsNext = BTN_NONE;
        if (w_numHigh >= 3'd2) begin
          w_stateNext = WAIT_RELEASE;
        end else if (w_numHigh == 3'd1) begin
          w_stateNext = ARM;
          w_btnsNext  = w_level;
        end
      end
      ARM: begin
        w_stateNext = PULSE;
      end
      PULSE: begin
        // Release or extra presses are deliberately ignored until HOLD
        if (r_pulseCnt >= c_pulseLast) begin
          w_stateNext = HOLD;
        end
      end
      HOLD: begin
        if (w_level == BTN_NONE) begin
          w_stateNext = IDLE;
          w_btnsNext  = BTN_NONE;
        end else if ((w_level & ~r_btns) != BTN_NONE) begin
          w_stateNext = WAIT_RELEASE;
          w_btnsNext  = BTN_NONE;
        end else if (w_repExpired) begin
          w_stateNext = PULSE;
        end
      end
      WAIT_RELEASE: begin
        w_btnsNext = BTN_NONE;
        if (w_level == BTN_NONE) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_btnsNext  = BTN_NONE;
      end
    endcase
  end

  // State register with registered (glitch-free) outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_btns    <= BTN_NONE;
      r_btnClk  <= 1'b0;
      r_btnHeld <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_btns    <= w_btnsNext;
      r_btnClk  <= (w_stateNext == PULSE);
      r_btnHeld <= (w_stateNext == ARM) || (w_stateNext == PULSE) ||
                   (w_stateNext == HOLD);
    end
  end

  // Strobe high-time counter, cleared whenever the strobe is not running
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pulseCnt <= '0;
    end else if (r_state == PULSE && w_stateNext == PULSE) begin
      if (r_pulseCnt < c_pulseLast) begin
        r_pulseCnt <= r_pulseCnt + 1'b1;
      end
    end else begin
      r_pulseCnt <= '0;
    end
  end

  assign btns    = r_btns;
  assign btnClk  = r_btnClk;
  assign btnHeld = r_btnHeld;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Directed self-checking bench for btn_conditioner with short
//            debounce/pulse/repeat parameters. Expected edges are counted
//            from the edge after which a stimulus is applied (edge 0).
//            Honours BTN_AUTOREPEAT_EN for the repeat-dependent checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int DEB   = 8;
  localparam int PUL   = 2;
  localparam int RDLY  = 20;
  localparam int RRATE = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnU, btnD, btnR, btnL;
  logic [3:0] btns;
  logic       btnClk;
  logic       btnHeld;

  int nChecks = 0;
  int nErrors = 0;

  logic       clkHist  [0:127];
  logic [3:0] btnsHist [0:127];
  logic       heldHist [0:127];

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btnU   (btnU),
    .btnD   (btnD),
    .btnR   (btnR),
    .btnL   (btnL),
    .btns   (btns),
    .btnClk (btnClk),
    .btnHeld(btnHeld)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to edge k and record outputs just after it
  task automatic step(input int k);
    @(posedge clk);
    #1;
    clkHist[k]  = btnClk;
    btnsHist[k] = btns;
    heldHist[k] = btnHeld;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int risesIn(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (clkHist[k] === 1'b1 && clkHist[k-1] === 1'b0) n++;
    return n;
  endfunction

  function automatic int clkHighIn(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (clkHist[k] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int btnsSetIn(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (btnsHist[k] !== 4'd0 || heldHist[k] !== 1'b0) n++;
    return n;
  endfunction

  initial begin
    rst = 1'b0; btnU = 1'b0; btnD = 1'b0; btnR = 1'b0; btnL = 1'b0;

    // Reset state
    idle(3);
    checkEq("reset_btns", btns, 0);
    checkEq("reset_clk", btnClk, 0);
    checkEq("reset_held", btnHeld, 0);
    rst = 1'b1;
    idle(5);

    // Clean press of U for 60 cycles
    step(0);
    btnU = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step(k);
      if (k == 60) btnU = 1'b0;
    end
    checkEq("clean_btns10", btnsHist[10], 0);
    checkEq("clean_btns11", btnsHist[11], 8);
    checkEq("clean_held10", heldHist[10], 0);
    checkEq("clean_held11", heldHist[11], 1);
    checkEq("clean_clk11", clkHist[11], 0);
    checkEq("clean_clk12", clkHist[12], 1);
    checkEq("clean_clk13", clkHist[13], 1);
    checkEq("clean_clk14", clkHist[14], 0);
    checkEq("clean_btns70", btnsHist[70], 8);
    checkEq("clean_btns71", btnsHist[71], 0);
    checkEq("clean_held71", heldHist[71], 0);
`ifdef BTN_AUTOREPEAT_EN
    checkEq("clean_clk31", clkHist[31], 0);
    checkEq("clean_clk32", clkHist[32], 1);
    checkEq("clean_clk42", clkHist[42], 1);
    checkEq("clean_rises", risesIn(1, 80), 5);
`else
    checkEq("clean_clk32", clkHist[32], 0);
    checkEq("clean_rises", risesIn(1, 80), 1);
`endif
    idle(20);

    // Bouncing D: toggles every 3 cycles, last toggle (to high) at edge 30
    step(0);
    btnD = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step(k);
      if (k <= 30) btnD = ((k / 3) % 2 == 0);
      if (k == 50) btnD = 1'b0;
    end
    checkEq("bounce_quiet", clkHighIn(1, 41), 0);
    checkEq("bounce_btns40", btnsHist[40], 0);
    checkEq("bounce_btns41", btnsHist[41], 4);
    checkEq("bounce_clk42", clkHist[42], 1);
    idle(30);

    // Simultaneous U+L, drop L, drop U, then press U again
    step(0);
    btnU = 1'b1; btnL = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step(k);
      if (k == 30) btnL = 1'b0;
      if (k == 60) btnU = 1'b0;
      if (k == 80) btnU = 1'b1;
      if (k == 95) btnU = 1'b0;
    end
    checkEq("simul_noclk", clkHighIn(1, 80), 0);
    checkEq("simul_nobtns", btnsSetIn(1, 80), 0);
    checkEq("simul_clk91", clkHist[91], 0);
    checkEq("simul_btns91", btnsHist[91], 8);
    checkEq("simul_clk92", clkHist[92], 1);
    idle(30);

    // R held, L added at edge 22 (debounced at 32, seen by the FSM at 33)
    step(0);
    btnR = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step(k);
      if (k == 22) btnL = 1'b1;
      if (k == 70) begin btnR = 1'b0; btnL = 1'b0; end
    end
    checkEq("second_btns11", btnsHist[11], 2);
`ifdef BTN_AUTOREPEAT_EN
    checkEq("second_clk32", clkHist[32], 1);
    checkEq("second_clk33", clkHist[33], 1);
    checkEq("second_clk34", clkHist[34], 0);
    checkEq("second_btns34", btnsHist[34], 2);
    checkEq("second_btns35", btnsHist[35], 0);
    checkEq("second_norep", risesIn(36, 70), 0);
`else
    checkEq("second_btns32", btnsHist[32], 2);
    checkEq("second_btns33", btnsHist[33], 0);
    checkEq("second_norep", risesIn(13, 70), 0);
`endif
    checkEq("second_held36", heldHist[36], 0);
    idle(30);

    // Reset asserted during the first strobe cycle
    step(0);
    btnU = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(k);
      if (k == 12) rst = 1'b0;
      if (k == 13) rst = 1'b1;
      if (k == 40) btnU = 1'b0;
    end
    checkEq("rstmid_clk12", clkHist[12], 1);
    checkEq("rstmid_clk13", clkHist[13], 0);
    checkEq("rstmid_btns13", btnsHist[13], 0);
    checkEq("rstmid_held13", heldHist[13], 0);
    checkEq("rstmid_quiet", clkHighIn(14, 24), 0);
    checkEq("rstmid_btns24", btnsHist[24], 8);
    checkEq("rstmid_clk25", clkHist[25], 1);
    idle(30);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
